// File: rtl/wb_slave_interface_pkg.sv
// Shared bus widths, FSM encodings and the buffered beat payload for the NIC WISHBONE slave.
package wb_slave_interface_pkg;

    localparam int unsigned BUS_ADDRESS_WIDTH = 32;
    localparam int unsigned BUS_DATA_WIDTH    = 32;
    localparam int unsigned GRANULARITY       = 8;
    localparam int unsigned SEL_WIDTH         = BUS_DATA_WIDTH / GRANULARITY;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        WRITE_BURST = 3'd1,
        READ_BURST  = 3'd2,
        COMMIT      = 3'd3,
        WAIT_REPLY  = 3'd4
    } state_t;

    typedef struct packed {
        logic                         we;
        logic [SEL_WIDTH-1:0]         sel;
        logic [BUS_ADDRESS_WIDTH-1:0] adr;
        logic [BUS_DATA_WIDTH-1:0]    dat;
    } beat_t;

endpackage

// File: rtl/wb_slave_interface_beat_fifo.sv
// Synchronous beat FIFO; pointers carry one extra bit so full and empty stay distinguishable.
module nic_beat_fifo
    import wb_slave_interface_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 3
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  push,
    input  beat_t din,
    input  logic  pop,
    output beat_t dout,
    output logic  full,
    output logic  empty
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned PTR_W = DEPTH_LOG2 + 1;

    beat_t              mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic               do_push;
    logic               do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                     (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
    assign dout    = mem[rd_ptr[DEPTH_LOG2-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        end
    end

    // Storage needs no reset: the read side is qualified by empty.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[DEPTH_LOG2-1:0]] <= din;
    end

endmodule

// File: rtl/wb_slave_interface.sv
// WISHBONE pipelined slave: buffers burst beats into a FIFO and reports message completion.
// Optional first-beat retry on a full FIFO is enabled with `define WB_SLAVE_RETRY_EN.
module wb_slave_interface
    import wb_slave_interface_pkg::*;
#(
    parameter int unsigned N_BITS_BURST_LENGHT = 7,
    parameter int unsigned FIFO_DEPTH_LOG2     = 3
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           CYC_I,
    input  logic                           STB_I,
    input  logic                           WE_I,
    input  logic [BUS_ADDRESS_WIDTH-1:0]   ADR_I,
    input  logic [BUS_DATA_WIDTH-1:0]      DAT_I,
    input  logic [SEL_WIDTH-1:0]           SEL_I,
    output logic                           ACK_O,
    output logic                           ERR_O,
    output logic                           RTY_O,
    output logic                           STALL_O,
    output logic                           beat_valid_o,
    input  logic                           beat_ready_i,
    output logic [BUS_ADDRESS_WIDTH-1:0]   beat_address_o,
    output logic [BUS_DATA_WIDTH-1:0]      beat_data_o,
    output logic [SEL_WIDTH-1:0]           beat_sel_o,
    output logic                           beat_we_o,
    output logic                           msg_done_o,
    output logic [N_BITS_BURST_LENGHT-1:0] msg_lenght_o,
    output logic                           read_pending_o,
    input  logic                           reply_done_i
);

    localparam logic [N_BITS_BURST_LENGHT-1:0] MAX_COUNT = '1;

    state_t                         state;
    state_t                         state_next;
    logic [N_BITS_BURST_LENGHT-1:0] beat_count;
    logic                           burst_we;
    logic                           fifo_full;
    logic                           fifo_empty;
    beat_t                          head;
    beat_t                          new_beat;
    logic                           strobe;
    logic                           in_burst;
    logic                           err_cond;
    logic                           accept;
    logic                           strobe_err;
    logic                           idle_retry;

    assign strobe   = CYC_I && STB_I;
    assign in_burst = (state == WRITE_BURST) || (state == READ_BURST);
    assign err_cond = (in_burst && (WE_I != burst_we)) || (beat_count == MAX_COUNT);

`ifdef WB_SLAVE_RETRY_EN
    logic rty_q;

    // A first beat meeting a full FIFO is bounced with a retry instead of a stall.
    assign idle_retry = (state == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rty_q <= 1'b0;
        else        rty_q <= strobe && idle_retry && fifo_full;
    end

    assign RTY_O = rty_q;
`else
    assign idle_retry = 1'b0;
    assign RTY_O      = 1'b0;
`endif

    assign STALL_O    = !rst_n || (fifo_full && !idle_retry) ||
                        (state == COMMIT) || (state == WAIT_REPLY);
    assign accept     = strobe && !STALL_O && !fifo_full && !err_cond;
    assign strobe_err = strobe && !STALL_O && err_cond;

    assign new_beat = '{we: WE_I, sel: SEL_I, adr: ADR_I, dat: DAT_I};

    nic_beat_fifo #(
        .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (accept),
        .din   (new_beat),
        .pop   (beat_ready_i),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Head fields are forced to zero while the FIFO is empty.
    assign beat_valid_o   = !fifo_empty;
    assign beat_address_o = fifo_empty ? '0 : head.adr;
    assign beat_data_o    = fifo_empty ? '0 : head.dat;
    assign beat_sel_o     = fifo_empty ? '0 : head.sel;
    assign beat_we_o      = !fifo_empty && head.we;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:        if (accept) state_next = WE_I ? WRITE_BURST : READ_BURST;
            WRITE_BURST,
            READ_BURST:  if (!CYC_I || !STB_I) state_next = COMMIT;
            COMMIT:      state_next = burst_we ? IDLE : WAIT_REPLY;
            WAIT_REPLY:  if (reply_done_i || !CYC_I) state_next = IDLE;
            default:     state_next = IDLE;
        endcase
    end

    // Burst bookkeeping and registered bus/queue responses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_count     <= '0;
            burst_we       <= 1'b0;
            ACK_O          <= 1'b0;
            ERR_O          <= 1'b0;
            msg_done_o     <= 1'b0;
            msg_lenght_o   <= '0;
            read_pending_o <= 1'b0;
        end else begin
            if (state == COMMIT)  beat_count <= '0;
            else if (accept)      beat_count <= beat_count + N_BITS_BURST_LENGHT'(1);
            if ((state == IDLE) && accept) burst_we <= WE_I;
            ACK_O          <= accept && WE_I;
            ERR_O          <= strobe_err;
            msg_done_o     <= (state_next == COMMIT);
            msg_lenght_o   <= (state_next == COMMIT) ? beat_count : '0;
            read_pending_o <= (state_next == WAIT_REPLY);
        end
    end

endmodule
